// File: rtl/button_events_if.sv
// Event bus between the debounced button level and the stopwatch control FSM.
// The DUT side is the slave modport; the button/driver side is the master.
interface button_events_if;
    logic i_btn;
    logic o_press;
    logic o_release;
    logic o_long_press;
    logic o_repeat;
    logic o_held;

    modport slave (
        input  i_btn,
        output o_press, o_release, o_long_press, o_repeat, o_held
    );

    modport master (
        output i_btn,
        input  o_press, o_release, o_long_press, o_repeat, o_held
    );
endinterface

// File: rtl/button_events.sv
// Turns a debounced button level into press/release/long-press/repeat strobes.
// Auto-repeat exists only when BUTTON_EVENTS_REPEAT_EN is defined.
module button_events #(
    parameter int CLK_FREQ_KHZ = 100_000,
    parameter int LONG_MS      = 1000,
    parameter int REPEAT_MS    = 200
) (
    input  logic           clk,
    input  logic           rst,
    button_events_if.slave bus
);
    localparam int PW = (CLK_FREQ_KHZ > 1) ? $clog2(CLK_FREQ_KHZ) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_FREQ_KHZ - 1);
    localparam logic [15:0]   LONG_LAST = 16'(LONG_MS - 1);

    if (LONG_MS < 1 || LONG_MS > 65535) begin : g_bad_long
        $error("button_events: LONG_MS out of range 1..65535");
    end
    if (REPEAT_MS < 1 || REPEAT_MS > 65535) begin : g_bad_repeat
        $error("button_events: REPEAT_MS out of range 1..65535");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESSED = 2'd1,
        S_LONG    = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_btn_q;
    logic [PW-1:0] r_pre;
    logic [15:0]   r_ms;
    logic          r_press, r_release, r_long_press, r_held;
    logic          w_press_nxt, w_release_nxt, w_long_nxt, w_cnt_clr;
    logic          w_rise, w_fall, w_tick;

    assign w_rise = bus.i_btn & ~r_btn_q;
    assign w_fall = ~bus.i_btn & r_btn_q;
    assign w_tick = (r_pre == PRE_LAST);

`ifdef BUTTON_EVENTS_REPEAT_EN
    localparam logic [15:0] REP_LAST = 16'(REPEAT_MS - 1);
    logic r_repeat;
    logic w_rep_nxt;
`endif

    // Loads even during reset so a button held through reset never looks like a rise.
    always_ff @(posedge clk) begin
        r_btn_q <= bus.i_btn;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Thresholds compare against the value ms_cnt is about to reach on this tick,
    // so the strobe lands exactly LONG_MS / REPEAT_MS ticks after the clear.
    always_comb begin
        w_state_nxt   = r_state;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_long_nxt    = 1'b0;
        w_cnt_clr     = 1'b0;
`ifdef BUTTON_EVENTS_REPEAT_EN
        w_rep_nxt     = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                w_cnt_clr = 1'b1;
                if (w_rise) begin
                    w_state_nxt = S_PRESSED;
                    w_press_nxt = 1'b1;
                end
            end
            S_PRESSED: begin
                if (w_fall) begin
                    w_state_nxt   = S_IDLE;
                    w_release_nxt = 1'b1;
                    w_cnt_clr     = 1'b1;
                end else if (w_tick && r_ms == LONG_LAST) begin
                    w_state_nxt = S_LONG;
                    w_long_nxt  = 1'b1;
                    w_cnt_clr   = 1'b1;
                end
            end
            S_LONG: begin
                if (w_fall) begin
                    w_state_nxt   = S_IDLE;
                    w_release_nxt = 1'b1;
                    w_cnt_clr     = 1'b1;
`ifdef BUTTON_EVENTS_REPEAT_EN
                end else if (w_tick && r_ms == REP_LAST) begin
                    w_rep_nxt = 1'b1;
                    w_cnt_clr = 1'b1;
                end
`else
                end else begin
                    w_cnt_clr = 1'b1;
                end
`endif
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_clr   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || w_cnt_clr) begin
            r_pre <= '0;
            r_ms  <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
            r_ms  <= r_ms + 16'd1;
        end else begin
            r_pre <= r_pre + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_press      <= 1'b0;
            r_release    <= 1'b0;
            r_long_press <= 1'b0;
            r_held       <= 1'b0;
        end else begin
            r_press      <= w_press_nxt;
            r_release    <= w_release_nxt;
            r_long_press <= w_long_nxt;
            r_held       <= (w_state_nxt != S_IDLE);
        end
    end

`ifdef BUTTON_EVENTS_REPEAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_repeat <= 1'b0;
        end else begin
            r_repeat <= w_rep_nxt;
        end
    end
    assign bus.o_repeat = r_repeat;
`else
    assign bus.o_repeat = 1'b0;
`endif

    assign bus.o_press      = r_press;
    assign bus.o_release    = r_release;
    assign bus.o_long_press = r_long_press;
    assign bus.o_held       = r_held;
endmodule

// File: tb/tb_button_events.sv
// Bench for button_events: timestamp-based reference model, directed scenarios
// followed by random button waveforms with occasional resets.
module tb_button_events;
    localparam int CLK_FREQ_KHZ = 10;
    localparam int LONG_MS      = 5;
    localparam int REPEAT_MS    = 2;
    localparam int LONG_CYC     = LONG_MS * CLK_FREQ_KHZ;
    localparam int REP_CYC      = REPEAT_MS * CLK_FREQ_KHZ;
`ifdef BUTTON_EVENTS_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif
    localparam int EXP_REPS_120 = REP_EN ? 3 : 0;

    logic clk = 1'b0;
    logic rst;
    button_events_if bus();

    button_events #(
        .CLK_FREQ_KHZ(CLK_FREQ_KHZ),
        .LONG_MS     (LONG_MS),
        .REPEAT_MS   (REPEAT_MS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: event times from the press timestamp, not from counters.
    longint k = 0;
    longint m_next = -1;
    logic   m_bq = 1'b0;
    logic   m_active = 1'b0;
    logic   m_is_long = 1'b0;
    logic   e_press, e_release, e_long, e_rep, e_held;
    int     n_press, n_rel, n_long, n_rep, n_held;

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s at edge %0d: got %b want %b", tag, k - 1, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic model(input logic b, input logic r);
        e_press = 1'b0; e_release = 1'b0; e_long = 1'b0; e_rep = 1'b0;
        if (r) begin
            m_active = 1'b0;
        end else if (m_active && !b && m_bq) begin
            e_release = 1'b1;
            m_active  = 1'b0;
        end else if (!m_active && b && !m_bq) begin
            e_press   = 1'b1;
            m_active  = 1'b1;
            m_is_long = 1'b0;
            m_next    = k + LONG_CYC;
        end else if (m_active && k == m_next) begin
            if (!m_is_long) begin
                e_long    = 1'b1;
                m_is_long = 1'b1;
            end else begin
                e_rep = 1'b1;
            end
            m_next = REP_EN ? k + REP_CYC : -1;
        end
        e_held = m_active;
        m_bq   = b;
        k++;
    endtask

    task automatic clr_counts();
        n_press = 0; n_rel = 0; n_long = 0; n_rep = 0; n_held = 0;
    endtask

    task automatic step(input logic b, input logic r);
        bus.i_btn = b;
        rst       = r;
        @(posedge clk);
        model(b, r);
        @(negedge clk);
        chk_bit("press",      bus.o_press,      e_press);
        chk_bit("release",    bus.o_release,    e_release);
        chk_bit("long_press", bus.o_long_press, e_long);
        chk_bit("repeat",     bus.o_repeat,     e_rep);
        chk_bit("held",       bus.o_held,       e_held);
        n_press += int'(bus.o_press);
        n_rel   += int'(bus.o_release);
        n_long  += int'(bus.o_long_press);
        n_rep   += int'(bus.o_repeat);
        n_held  += int'(bus.o_held);
    endtask

    task automatic run(input logic b, input logic r, input int n);
        for (int i = 0; i < n; i++) step(b, r);
    endtask

    initial begin
        int   len;
        logic b;
        bit   r;

        bus.i_btn = 1'b0;
        rst       = 1'b1;
        @(negedge clk);

        // Reset state
        clr_counts();
        run(1'b0, 1'b1, 3);
        chk_int("reset_held_cycles", n_held, 0);

        // Short press: 20 cycles high
        run(1'b0, 1'b0, 5);
        clr_counts();
        run(1'b1, 1'b0, 20);
        run(1'b0, 1'b0, 5);
        chk_int("short_press_cnt", n_press, 1);
        chk_int("short_rel_cnt",   n_rel,   1);
        chk_int("short_held_cyc",  n_held,  20);
        chk_int("short_long_cnt",  n_long,  0);

        // Long hold: 120 cycles high
        clr_counts();
        run(1'b1, 1'b0, 120);
        run(1'b0, 1'b0, 5);
        chk_int("long_long_cnt", n_long, 1);
        chk_int("long_rep_cnt",  n_rep,  EXP_REPS_120);
        chk_int("long_rel_cnt",  n_rel,  1);

        // Fall sampled on the edge where long_press would be produced
        clr_counts();
        run(1'b1, 1'b0, LONG_CYC);
        run(1'b0, 1'b0, 5);
        chk_int("thresh_long_cnt", n_long, 0);
        chk_int("thresh_rel_cnt",  n_rel,  1);

        // Button held across reset: no press, no release
        clr_counts();
        run(1'b1, 1'b1, 3);
        run(1'b1, 1'b0, 10);
        run(1'b0, 1'b0, 5);
        chk_int("rsthold_press_cnt", n_press, 0);
        chk_int("rsthold_rel_cnt",   n_rel,   0);

        // Reset in LONG at P+60, then a fresh press
        clr_counts();
        run(1'b1, 1'b0, 60);
        run(1'b1, 1'b1, 2);
        chk_int("rstlong_rel_cnt", n_rel, 0);
        chk_int("rstlong_rep_cnt", n_rep, REP_EN ? 0 : 0);
        run(1'b0, 1'b0, 3);
        clr_counts();
        run(1'b1, 1'b0, LONG_CYC + 1);
        chk_int("fresh_press_cnt", n_press, 1);
        chk_int("fresh_long_cnt",  n_long,  1);
        run(1'b0, 1'b0, 3);

        // Random waveforms with occasional short resets
        for (int s = 0; s < 60; s++) begin
            len = $urandom_range(1, 90);
            b   = logic'($urandom_range(0, 1));
            r   = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < len; i++) step(b, r && (i < 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
